// File: rtl/tpi_parallel_link.sv
// Drive-side byte handshake engine for a 6525 TPI port A / CA link.
// Host bytes go into an RX FIFO; drive bytes are presented and handshaken out.
module tpi_parallel_link #(
  parameter int DEPTH       = 4,
  parameter int TIMEOUT     = 255,
  parameter int SYNC_STAGES = 2
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic [7:0]               pa_in,
  output logic [7:0]               pa_out,
  output logic                     pa_oe,
  input  logic                     strobe_n,
  output logic                     ack_n,
  input  logic                     dir,
  output logic [7:0]               rx_data,
  output logic                     rx_valid,
  input  logic                     rx_ready,
  input  logic [7:0]               tx_data,
  input  logic                     tx_valid,
  output logic                     tx_ready,
  output logic [$clog2(DEPTH):0]   rx_count,
  output logic                     timeout_err,
  input  logic                     clear_err
);

  localparam int AW = $clog2(DEPTH);
  localparam int TB = $clog2(TIMEOUT + 1);
  localparam int TW = (TB > 8) ? TB : 8;

  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT - 1);
  localparam logic [TW-1:0] TMO_ONE  = TW'(1);
  localparam logic [AW:0]   FULL_CNT = (AW + 1)'(DEPTH);
  localparam logic [AW:0]   CNT_ONE  = (AW + 1)'(1);
  localparam logic [AW-1:0] PTR_ONE  = AW'(1);

  typedef enum logic [2:0] {
    IDLE,
    RX_FULL,
    RX_ACK,
    TX_SETUP,
    TX_WAIT_LO,
    TX_WAIT_HI
  } state_t;

  state_t state_q, state_d;

  logic [SYNC_STAGES-1:0] strb_sync_q;
  logic [7:0]             pa_sync_q [SYNC_STAGES];
  logic                   strb_hist_q;
  logic                   strb_s;
  logic [7:0]             pa_s;
  logic                   fall;
  logic                   rise;

  logic [7:0]    mem_q [DEPTH];
  logic [AW-1:0] wp_q;
  logic [AW-1:0] rp_q;
  logic [AW:0]   cnt_q;
  logic          full;
  logic          push;
  logic          pop;

  logic          ack_q, ack_d;
  logic          oe_q, oe_d;
  logic [7:0]    out_q, out_d;
  logic          txr_q, txr_d;
  logic          err_q, err_d;
  logic [TW-1:0] tmo_q, tmo_d;
  logic          tmo_hit;
  logic          tmo_fire;
  logic          counting;

  assign strb_s = strb_sync_q[SYNC_STAGES-1];
  assign pa_s   = pa_sync_q[SYNC_STAGES-1];
  assign fall   = ~strb_s & strb_hist_q;
  assign rise   = strb_s & ~strb_hist_q;

  assign full     = (cnt_q == FULL_CNT);
  assign rx_valid = (cnt_q != '0);
  assign pop      = rx_valid & rx_ready;
  assign rx_data  = mem_q[rp_q];
  assign rx_count = cnt_q;

  assign pa_out      = out_q;
  assign pa_oe       = oe_q;
  assign ack_n       = ack_q;
  assign tx_ready    = txr_q;
  assign timeout_err = err_q;

  assign tmo_hit  = (tmo_q == TMO_LAST);
  assign counting = (state_q == RX_ACK) ||
                    (state_q == TX_WAIT_LO) ||
                    (state_q == TX_WAIT_HI);

  // Strobe and data share the same synchronizer depth so they stay aligned.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      strb_sync_q <= '1;
      strb_hist_q <= 1'b1;
      for (int i = 0; i < SYNC_STAGES; i++) begin
        pa_sync_q[i] <= '0;
      end
    end else begin
      strb_sync_q <= {strb_sync_q[SYNC_STAGES-2:0], strobe_n};
      strb_hist_q <= strb_s;
      pa_sync_q[0] <= pa_in;
      for (int i = 1; i < SYNC_STAGES; i++) begin
        pa_sync_q[i] <= pa_sync_q[i-1];
      end
    end
  end

  // RX FIFO storage, pointers and occupancy.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wp_q  <= '0;
      rp_q  <= '0;
      cnt_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      if (push) begin
        mem_q[wp_q] <= pa_s;
        wp_q        <= wp_q + PTR_ONE;
      end
      if (pop) begin
        rp_q <= rp_q + PTR_ONE;
      end
      unique case ({push, pop})
        2'b10:   cnt_q <= cnt_q + CNT_ONE;
        2'b01:   cnt_q <= cnt_q - CNT_ONE;
        default: cnt_q <= cnt_q;
      endcase
    end
  end

  // Handshake state and registered port outputs.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      ack_q   <= 1'b1;
      oe_q    <= 1'b0;
      out_q   <= '0;
      txr_q   <= 1'b0;
      err_q   <= 1'b0;
      tmo_q   <= '0;
    end else begin
      state_q <= state_d;
      ack_q   <= ack_d;
      oe_q    <= oe_d;
      out_q   <= out_d;
      txr_q   <= txr_d;
      err_q   <= err_d;
      tmo_q   <= tmo_d;
    end
  end

  // Next-state logic for the handshake FSM and its watchdog.
  always_comb begin
    state_d  = state_q;
    ack_d    = ack_q;
    oe_d     = oe_q;
    out_d    = out_q;
    txr_d    = 1'b0;
    push     = 1'b0;
    tmo_fire = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (!dir) begin
          if (fall) begin
            if (!full) begin
              push    = 1'b1;
              ack_d   = 1'b0;
              state_d = RX_ACK;
            end else begin
              state_d = RX_FULL;
            end
          end
        end else if (tx_valid) begin
          out_d   = tx_data;
          oe_d    = 1'b1;
          txr_d   = 1'b1;
          state_d = TX_SETUP;
        end
      end
      RX_FULL: begin
        if (!full || pop) begin
          push    = 1'b1;
          ack_d   = 1'b0;
          state_d = RX_ACK;
        end
      end
      RX_ACK: begin
        if (rise) begin
          ack_d   = 1'b1;
          state_d = IDLE;
        end else if (tmo_hit) begin
          tmo_fire = 1'b1;
        end
      end
      TX_SETUP: begin
        ack_d   = 1'b0;
        state_d = TX_WAIT_LO;
      end
      TX_WAIT_LO: begin
        if (fall) begin
          state_d = TX_WAIT_HI;
        end else if (tmo_hit) begin
          tmo_fire = 1'b1;
        end
      end
      TX_WAIT_HI: begin
        if (rise) begin
          ack_d   = 1'b1;
          oe_d    = 1'b0;
          state_d = IDLE;
        end else if (tmo_hit) begin
          tmo_fire = 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    if (tmo_fire) begin
      ack_d   = 1'b1;
      oe_d    = 1'b0;
      state_d = IDLE;
    end

    if (clear_err) begin
      err_d = 1'b0;
    end else begin
      err_d = err_q | tmo_fire;
    end

    if (state_d != state_q) begin
      tmo_d = '0;
    end else if (counting) begin
      tmo_d = tmo_q + TMO_ONE;
    end else begin
      tmo_d = tmo_q;
    end
  end

endmodule
